// File: rtl/intc.sv
// Six-source interrupt controller: rising-edge capture into W1C pending bits, mask, global enable, overrun flags.
// PEND updates 1 cycle after an IRQ_I rising edge; HWINT_O/INT_O follow 1 cycle later. There is no backpressure.
module intc (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        WE_I,
  input  logic [3:2]  ADD_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  input  logic [5:0]  IRQ_I,
  output logic [5:0]  HWINT_O,
  output logic        INT_O
);

  localparam logic [1:0] A_PEND = 2'b00;
  localparam logic [1:0] A_MASK = 2'b01;
  localparam logic [1:0] A_CTRL = 2'b10;
  localparam logic [1:0] A_VECT = 2'b11;

  logic [5:0] r_irq_q;
  logic [5:0] r_pend;
  logic [5:0] r_mask;
  logic       r_gen;
  logic [5:0] r_ovr;
  logic [5:0] r_hwint;
  logic       r_int;

  logic [5:0] w_edge;
  logic       w_wr_pend;
  logic       w_wr_mask;
  logic       w_wr_ctrl;
  logic [5:0] w_pend_clr;
  logic [5:0] w_ovr_clr;
  logic [5:0] w_pend_nxt;
  logic [5:0] w_ovr_nxt;
  logic [5:0] w_act;
  logic [2:0] w_idx;
  logic       w_unused;

  assign w_edge    = IRQ_I & ~r_irq_q;
  assign w_wr_pend = WE_I && (ADD_I == A_PEND);
  assign w_wr_mask = WE_I && (ADD_I == A_MASK);
  assign w_wr_ctrl = WE_I && (ADD_I == A_CTRL);

  assign w_pend_clr = w_wr_pend ? DAT_I[5:0]  : 6'b0;
  assign w_ovr_clr  = w_wr_ctrl ? DAT_I[13:8] : 6'b0;

  // Setting is OR'ed in after the clear so a same-cycle edge always wins.
  assign w_pend_nxt = (r_pend & ~w_pend_clr) | w_edge;
  assign w_ovr_nxt  = (r_ovr  & ~w_ovr_clr)  | (w_edge & r_pend);

  assign w_act    = r_pend & r_mask & {6{r_gen}};
  assign w_unused = ^{DAT_I[31:14], DAT_I[7:6]};

  always_comb begin
    w_idx = 3'd7;
    for (int i = 5; i >= 0; i--) begin
      if (w_act[i]) w_idx = i[2:0];
    end
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      r_irq_q <= 6'b0;
      r_pend  <= 6'b0;
      r_mask  <= 6'b0;
      r_gen   <= 1'b0;
      r_ovr   <= 6'b0;
      r_hwint <= 6'b0;
      r_int   <= 1'b0;
    end else begin
      r_irq_q <= IRQ_I;
      r_pend  <= w_pend_nxt;
      r_ovr   <= w_ovr_nxt;
      r_hwint <= w_act;
      r_int   <= |w_act;
      if (w_wr_mask) r_mask <= DAT_I[5:0];
      if (w_wr_ctrl) r_gen  <= DAT_I[0];
    end
  end

  always_comb begin
    DAT_O = 32'b0;
    case (ADD_I)
      A_PEND: DAT_O = {26'b0, r_pend};
      A_MASK: DAT_O = {26'b0, r_mask};
      A_CTRL: DAT_O = {18'b0, r_ovr, 7'b0, r_gen};
      A_VECT: DAT_O = {r_int, 28'b0, w_idx};
      default: DAT_O = 32'b0;
    endcase
  end

  assign HWINT_O = r_hwint;
  assign INT_O   = r_int;

endmodule
